// File: rtl/mem_access_unit_if.sv
// Request/status and byte-serial memory bus bundle for mem_access_unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface mem_access_unit_if;
    logic        start;
    logic        is_load;
    logic [3:0]  wme;
    logic [1:0]  muxlm;
    logic        su;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport slave (
        input  start, is_load, wme, muxlm, su, addr, wdata, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done, err, rdata
    );

    modport master (
        output start, is_load, wme, muxlm, su, addr, wdata, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done, err, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine: splits a 1/2/4-byte access into single-byte
// memory transactions, assembling and extending load data little-endian.
module mem_access_unit (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  last_q, last_d;
    logic        is_load_q, is_load_d;
    logic        su_q, su_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;

    logic        legal;
    logic [1:0]  last_sel;
    logic [4:0]  lane_sh;
    logic [31:0] asm_ins;
    logic [31:0] asm_ext;

    // Size decode: last_sel is the final byte index (n-1).
    always_comb begin
        legal    = 1'b1;
        last_sel = 2'd0;
        if (bus.is_load) begin
            unique case (bus.muxlm)
                2'b01:   last_sel = 2'd0;
                2'b00:   last_sel = 2'd1;
                2'b10:   last_sel = 2'd3;
                default: legal    = 1'b0;
            endcase
        end else begin
            case (bus.wme)
                4'b0001: last_sel = 2'd0;
                4'b0011: last_sel = 2'd1;
                4'b1111: last_sel = 2'd3;
                default: legal    = 1'b0;
            endcase
        end
    end

    assign lane_sh = {k_q, 3'b000};
    assign asm_ins = (asm_q & ~(32'h0000_00FF << lane_sh)) |
                     (32'(bus.mem_rdata) << lane_sh);

    always_comb begin
        unique case (last_q)
            2'd0:    asm_ext = {{24{su_q & asm_ins[7]}},  asm_ins[7:0]};
            2'd1:    asm_ext = {{16{su_q & asm_ins[15]}}, asm_ins[15:0]};
            default: asm_ext = asm_ins;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        is_load_d = is_load_q;
        su_d      = su_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_load_d = bus.is_load;
                    su_d      = bus.su;
                    addr_d    = bus.addr;
                    wdata_d   = bus.wdata;
                    last_d    = last_sel;
                    k_d       = '0;
                    asm_d     = '0;
                    err_d     = ~legal;
                    state_d   = legal ? XFER : FIN;
                end
            end
            XFER: begin
                if (bus.mem_ack) begin
                    if (is_load_q) asm_d = asm_ins;
                    k_d = k_q + 2'd1;
                    if (k_q == last_q) begin
                        state_d = FIN;
                        if (is_load_q) rdata_d = asm_ext;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_q    <= '0;
            is_load_q <= 1'b0;
            su_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            is_load_q <= is_load_d;
            su_q      <= su_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            asm_q     <= asm_d;
            rdata_q   <= rdata_d;
        end
    end

    // Bus outputs decode from state only, so reset clears them without a clock.
    logic xfer;
    assign xfer          = (state_q == XFER);
    assign bus.mem_req   = xfer;
    assign bus.mem_we    = xfer & ~is_load_q;
    assign bus.mem_addr  = xfer ? addr_q + {30'd0, k_q} : '0;
    assign bus.mem_wdata = xfer ? 8'(wdata_q >> lane_sh) : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = (state_q == FIN) & err_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] lw_bytes [4];
    logic [7:0] wr_bytes [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, ".mem_req"},   32'(bus.mem_req),   32'd0);
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, ".mem_addr"},  bus.mem_addr,       32'd0);
        chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.is_load = 1'b0; bus.wme = 4'b0000; bus.muxlm = 2'b00;
        bus.su = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_idle_bus("rst");
        chk("rst.busy",  32'(bus.busy),  32'd0);
        chk("rst.done",  32'(bus.done),  32'd0);
        chk("rst.err",   32'(bus.err),   32'd0);
        chk("rst.rdata", bus.rdata,      32'd0);
        rst_n = 1'b1;

        // Load word, zero-wait
        lw_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        @(negedge clk);
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b10; bus.su = 1'b1;
        bus.addr = 32'h0000_0100; bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("lw.req%0d", i),  32'(bus.mem_req), 32'd1);
            chk($sformatf("lw.we%0d", i),   32'(bus.mem_we),  32'd0);
            chk($sformatf("lw.addr%0d", i), bus.mem_addr,     32'h0000_0100 + 32'(i));
            chk($sformatf("lw.done%0d", i), 32'(bus.done),    32'd0);
            bus.mem_rdata = lw_bytes[i];
        end
        @(negedge clk);
        chk("lw.done",  32'(bus.done), 32'd1);
        chk("lw.err",   32'(bus.err),  32'd0);
        chk("lw.rdata", bus.rdata,     32'h1234_5678);
        chk_idle_bus("lw.fin");
        @(negedge clk);
        chk("lw.idle_busy", 32'(bus.busy), 32'd0);
        chk("lw.idle_done", 32'(bus.done), 32'd0);
        bus.mem_ack = 1'b0;

        // Load byte, sign- then zero-extended
        for (int s = 1; s >= 0; s--) begin
            @(negedge clk);
            bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b01; bus.su = 1'(s);
            bus.addr = 32'h0000_0123;
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("lb%0d.addr", s), bus.mem_addr, 32'h0000_0123);
            bus.mem_ack = 1'b1; bus.mem_rdata = 8'h80;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk($sformatf("lb%0d.done", s), 32'(bus.done), 32'd1);
            chk($sformatf("lb%0d.rdata", s), bus.rdata, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
            @(negedge clk);
        end

        // Store half, ack after 3 wait cycles per byte
        @(negedge clk);
        bus.start = 1'b1; bus.is_load = 1'b0; bus.wme = 4'b0011;
        bus.wdata = 32'hAABB_CCDD; bus.addr = 32'h0000_0200;
        wr_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int j = 0; j < 2; j++) begin
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                bus.start = 1'b0;
                chk($sformatf("sh.req%0d_%0d", j, w),   32'(bus.mem_req),   32'd1);
                chk($sformatf("sh.we%0d_%0d", j, w),    32'(bus.mem_we),    32'd1);
                chk($sformatf("sh.addr%0d_%0d", j, w),  bus.mem_addr,       32'h0000_0200 + 32'(j));
                chk($sformatf("sh.wdata%0d_%0d", j, w), 32'(bus.mem_wdata), 32'(wr_bytes[j]));
                chk($sformatf("sh.done%0d_%0d", j, w),  32'(bus.done),      32'd0);
                bus.mem_ack = (w == 3);
            end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("sh.done",  32'(bus.done), 32'd1);
        chk("sh.err",   32'(bus.err),  32'd0);
        chk("sh.rdata", bus.rdata,     32'h0000_0080);
        @(negedge clk);
        chk("sh.done_once", 32'(bus.done), 32'd0);
        chk("sh.idle",      32'(bus.busy), 32'd0);

        // Load word across the address wrap, zero-extended
        lw_bytes = '{8'h01, 8'h02, 8'h03, 8'h84};
        @(negedge clk);
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b10; bus.su = 1'b0;
        bus.addr = 32'hFFFF_FFFE; bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("wrap.addr%0d", i), bus.mem_addr, 32'hFFFF_FFFE + 32'(i));
            bus.mem_rdata = lw_bytes[i];
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("wrap.done",  32'(bus.done), 32'd1);
        chk("wrap.rdata", bus.rdata,     32'h8403_0201);

        // Illegal store wme=0101 and illegal load muxlm=11
        @(negedge clk);
        bus.start = 1'b1; bus.is_load = 1'b0; bus.wme = 4'b0101;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ill_st.done",  32'(bus.done), 32'd1);
        chk("ill_st.err",   32'(bus.err),  32'd1);
        chk("ill_st.rdata", bus.rdata,     32'h8403_0201);
        chk_idle_bus("ill_st");
        @(negedge clk);
        chk("ill_st.busy", 32'(bus.busy), 32'd0);
        chk("ill_st.err0", 32'(bus.err),  32'd0);
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b11;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ill_ld.err",     32'(bus.err),     32'd1);
        chk("ill_ld.mem_req", 32'(bus.mem_req), 32'd0);
        chk("ill_ld.rdata",   bus.rdata,        32'h8403_0201);
        @(negedge clk);

        // Start while busy and start during FIN are both ignored
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b00; bus.su = 1'b0;
        bus.addr = 32'h0000_0300;
        @(negedge clk);
        bus.is_load = 1'b0; bus.wme = 4'b0001; bus.addr = 32'h0000_0500;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy.addr0", bus.mem_addr,    32'h0000_0300);
        chk("busy.we0",   32'(bus.mem_we), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
        @(negedge clk);
        bus.start = 1'b1;
        chk("busy.addr1", bus.mem_addr, 32'h0000_0301);
        bus.mem_rdata = 8'h22;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("busy.done",  32'(bus.done), 32'd1);
        chk("busy.rdata", bus.rdata,     32'h0000_2211);
        @(negedge clk);
        bus.start = 1'b0;
        chk("fin_start.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("fin_start.busy2", 32'(bus.busy), 32'd0);

        // Reset after two bytes of a word load
        lw_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b10; bus.su = 1'b1;
        bus.addr = 32'h0000_0400; bus.mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.mem_rdata = lw_bytes[i];
        end
        @(negedge clk);
        chk("rmid.addr2", bus.mem_addr, 32'h0000_0402);
        rst_n = 1'b0;
        #1;
        chk_idle_bus("rmid");
        chk("rmid.busy",  32'(bus.busy), 32'd0);
        chk("rmid.done",  32'(bus.done), 32'd0);
        chk("rmid.err",   32'(bus.err),  32'd0);
        chk("rmid.rdata", bus.rdata,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmid.late_busy%0d", i), 32'(bus.busy), 32'd0);
            chk($sformatf("rmid.late_done%0d", i), 32'(bus.done), 32'd0);
        end
        bus.mem_ack = 1'b0;
        bus.start = 1'b1; bus.is_load = 1'b1; bus.muxlm = 2'b01; bus.su = 1'b1;
        bus.addr = 32'h0000_0410;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post.addr", bus.mem_addr, 32'h0000_0410);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h7F;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("post.done",  32'(bus.done), 32'd1);
        chk("post.rdata", bus.rdata,     32'h0000_007F);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  accept one access request when idle.
REQ-004 SHALL have ports: is_load  in  1  1 = load, 0 = store.
REQ-005 SHALL have ports: wme  in  4  store byte enables: 0001 = byte, 0011 = half, 1111 = word.
REQ-006 SHALL have ports: muxlm  in  2  load size: 01 = byte, 00 = half, 10 = word.
REQ-007 SHALL have ports: su  in  1  1 = sign-extend load result, 0 = zero-extend.
REQ-008 SHALL have ports: addr  in  32  base byte address; wdata  in  32  store data.
REQ-009 SHALL have ports: mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  8  byte-serial memory request.
REQ-010 SHALL have ports: mem_rdata  in  8, mem_ack  in  1  memory response, byte valid when mem_ack = 1.
REQ-011 SHALL have ports: busy  out  1, done  out  1, err  out  1, rdata  out  32  status and load result.

Function
REQ-012 SHALL implement an FSM with states IDLE, XFER and FIN; busy = (state != IDLE).
REQ-013 In IDLE, start = 1 SHALL latch is_load, wme, muxlm, su, addr and wdata, and SHALL clear the byte counter k.
REQ-014 start SHALL be ignored while busy = 1; no queuing.
REQ-015 Byte count n: loads 01 -> 1, 00 -> 2, 10 -> 4; stores 0001 -> 1, 0011 -> 2, 1111 -> 4.
REQ-016 Illegal size (load muxlm = 11; store wme not in {0001, 0011, 1111}, including 0000) SHALL go IDLE -> FIN with no memory request, pulse err with done, and leave rdata unchanged.
REQ-017 For a legal size, the FSM SHALL go IDLE -> XFER on the edge that accepts start.
REQ-018 In XFER, mem_req SHALL be 1, mem_addr = addr + k (mod 2^32, wraps), and mem_we = ~is_load.
REQ-019 In XFER, mem_wdata = wdata[8k+7:8k] (little-endian).
REQ-020 mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack = 1; waiting on ack has no timeout.
REQ-021 On mem_ack in XFER, a load SHALL capture mem_rdata into byte lane k of an internal assembly register.
REQ-022 On mem_ack in XFER, k SHALL increment; if k = n-1, the FSM SHALL go to FIN.
REQ-023 Outside XFER, mem_req = 0, mem_we = 0, mem_addr = 0 and mem_wdata = 0.
REQ-024 Zero-wait-state latency (ack every cycle): start at cycle 0 -> bytes at cycles 1..n -> done at cycle n+1 -> IDLE at n+2.
REQ-025 In FIN, done SHALL be 1 for exactly one cycle; the next state is IDLE.
REQ-026 On a load done, rdata SHALL update to the assembled value, extended from bit 8n-1: sign-extended if su = 1, zero-extended if su = 0.
REQ-027 On a store done, rdata SHALL be unchanged.
REQ-028 rdata SHALL hold its value until the next successful load completes.
REQ-029 mem_ack outside XFER SHALL be ignored.
REQ-030 Misaligned addresses SHALL NOT be checked; every access is byte-serial, so alignment is irrelevant.
REQ-031 A start presented in the FIN cycle SHALL be ignored; a new request is accepted only in IDLE.

Reset
REQ-032 rst_n = 0 SHALL immediately force state = IDLE and k = 0.
REQ-033 rst_n = 0 SHALL immediately force mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0, err = 0 and rdata = 0.
REQ-034 Reset during XFER SHALL abort the access with no done pulse; a late mem_ack after release SHALL be ignored.

Verification
REQ-035 Load word: addr = 0x100, muxlm = 10, su = 1, memory bytes 0x78, 0x56, 0x34, 0x12, zero-wait -> mem_addr 0x100..0x103 on cycles 1-4, done at cycle 5, rdata = 0x12345678.
REQ-036 Load byte: muxlm = 01, mem byte 0x80 -> rdata = 0xFFFFFF80 with su = 1, and 0x00000080 with su = 0.
REQ-037 Store half: wme = 0011, wdata = 0xAABBCCDD, addr = 0x200, ack delayed 3 cycles per byte -> writes 0xDD@0x200 then 0xCC@0x201, signals stable while waiting, done once, rdata unchanged.
REQ-038 Wrap and illegal: load word at addr = 0xFFFFFFFE -> mem_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001; store with wme = 0101 -> no mem_req, done = err = 1 at cycle 1.
REQ-039 Start while busy: start pulsed during XFER -> ignored, the original transfer completes unchanged.
REQ-040 Reset mid-op: rst_n low after byte 2 of a word load -> outputs reset at once, no done; the next load completes normally.
